// File: rtl/enemy_control.sv
// Per-frame sequencer for the enemy handshake: delivers latched hits, broadcasts
// gen_move/apply_move, then walks a one-hot draw across the enemies.
module enemy_control #(
    parameter int NUM_ENEMIES  = 4,
    parameter int DRAW_TIMEOUT = 300,
    parameter int IDX_W        = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [NUM_ENEMIES-1:0] attack_hit,
    input  logic [NUM_ENEMIES-1:0] draw_done,
    output logic                   init,
    output logic                   idle,
    output logic                   gen_move,
    output logic                   apply_move,
    output logic [NUM_ENEMIES-1:0] draw,
    output logic [NUM_ENEMIES-1:0] hit,
    output logic                   busy,
    output logic                   frame_done,
    output logic [NUM_ENEMIES-1:0] draw_err,
    output logic                   overrun
);

    localparam int TCNT_W = $clog2(DRAW_TIMEOUT) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
    localparam logic [TCNT_W-1:0] TCNT_END = TCNT_W'(DRAW_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_HIT, S_GEN, S_APPLY, S_DRAW, S_ACK, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [TCNT_W-1:0]      tcnt;
    logic [NUM_ENEMIES-1:0] pending;
    logic [NUM_ENEMIES-1:0] err_q;
    logic                   overrun_q;
    logic                   done_cur;
    logic                   timeout;

    assign done_cur = draw_done[idx];
    assign timeout  = (tcnt == TCNT_END);

    always_ff @(posedge clock) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        init       = 1'b0;
        idle       = 1'b0;
        gen_move   = 1'b0;
        apply_move = 1'b0;
        draw       = '0;
        hit        = '0;
        busy       = 1'b1;
        frame_done = 1'b0;
        draw_err   = err_q;
        overrun    = overrun_q;
        case (state)
            S_INIT: begin
                init      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                idle = 1'b1;
                busy = 1'b0;
                if (frame_start)
                    state_nxt = ((pending | attack_hit) != '0) ? S_HIT : S_GEN;
            end
            S_HIT: begin
                hit       = pending;
                state_nxt = S_GEN;
            end
            S_GEN: begin
                gen_move  = 1'b1;
                state_nxt = S_APPLY;
            end
            S_APPLY: begin
                apply_move = 1'b1;
                state_nxt  = S_DRAW;
            end
            S_DRAW: begin
                draw = NUM_ENEMIES'(1) << idx;
                if (done_cur || timeout) state_nxt = S_ACK;
            end
            S_ACK: begin
                // idle for one cycle lets the enemy drop its draw_done level
                idle      = 1'b1;
                state_nxt = (idx == LAST_IDX) ? S_DONE : S_DRAW;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
        // every output, sticky flags included, reads zero while reset is held
        if (reset) begin
            init       = 1'b0;
            idle       = 1'b0;
            gen_move   = 1'b0;
            apply_move = 1'b0;
            draw       = '0;
            hit        = '0;
            busy       = 1'b0;
            frame_done = 1'b0;
            draw_err   = '0;
            overrun    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            tcnt      <= '0;
            pending   <= '0;
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // a hit arriving during HIT itself is kept for the next frame
            pending <= (state == S_HIT) ? attack_hit : (pending | attack_hit);
            if (frame_start && state != S_IDLE) overrun_q <= 1'b1;
            case (state)
                S_APPLY: begin
                    idx  <= '0;
                    tcnt <= '0;
                end
                S_DRAW: begin
                    if (tcnt != '1) tcnt <= tcnt + 1'b1;
                    if (timeout && !done_cur) err_q[idx] <= 1'b1;
                end
                S_ACK: begin
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                    tcnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_control.sv
// Bench for enemy_control: behavioural enemies plus a schedule-queue model of the
// expected per-cycle outputs, with directed scenarios followed by random traffic.
module tb_enemy_control;

    localparam int N = 4;
    localparam int T = 300;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         frame_start = 1'b0;
    logic [N-1:0] attack_hit = '0;
    logic [N-1:0] draw_done = '0;
    logic         init, idle, gen_move, apply_move, busy, frame_done, overrun;
    logic [N-1:0] draw, hit, draw_err;

    enemy_control #(.NUM_ENEMIES(N), .DRAW_TIMEOUT(T), .IDX_W(2)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .attack_hit(attack_hit), .draw_done(draw_done),
        .init(init), .idle(idle), .gen_move(gen_move), .apply_move(apply_move),
        .draw(draw), .hit(hit), .busy(busy), .frame_done(frame_done),
        .draw_err(draw_err), .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         init;
        logic         idle;
        logic         gen;
        logic         apply;
        logic [N-1:0] draw;
        logic         hitcyc;
        logic         done;
        logic         busy;
        logic [N-1:0] errset;
    } rec_t;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t         sched[$];
    rec_t         cur;
    logic [N-1:0] pend = '0;
    logic [N-1:0] eerr = '0;
    logic         eov  = 1'b0;
    int           d[N] = '{5, 5, 5, 5};
    int           dir_d[N] = '{5, 5, 5, 5};
    int           cnt[N] = '{0, 0, 0, 0};
    bit           use_dir = 1'b1;

    int fd_count = 0;
    int run[N] = '{0, 0, 0, 0};
    int last_run[N] = '{0, 0, 0, 0};

    function automatic rec_t mk(input logic i, input logic id, input logic g, input logic a,
                                input logic [N-1:0] dr, input logic hc, input logic dn,
                                input logic b, input logic [N-1:0] es);
        rec_t r;
        r.init = i; r.idle = id; r.gen = g; r.apply = a; r.draw = dr;
        r.hitcyc = hc; r.done = dn; r.busy = b; r.errset = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Plan the whole frame at the moment it is accepted: the enemy delays are known,
    // so each draw window length is min(delay, timeout) (a pre-raised level gives 1).
    task automatic accept(input logic [N-1:0] ah);
        int len;
        for (int k = 0; k < N; k++) begin
            if (use_dir) d[k] = dir_d[k];
            else begin
                case ($urandom_range(0, 9))
                    0:       d[k] = 0;
                    1:       d[k] = $urandom_range(295, 305);
                    2:       d[k] = 1000;
                    default: d[k] = $urandom_range(1, 12);
                endcase
            end
            cnt[k] = 0;
            draw_done[k] = (d[k] == 0);
        end
        if ((pend | ah) != '0) sched.push_back(mk(0, 0, 0, 0, '0, 1, 0, 1, '0));
        sched.push_back(mk(0, 0, 1, 0, '0, 0, 0, 1, '0));
        sched.push_back(mk(0, 0, 0, 1, '0, 0, 0, 1, '0));
        for (int k = 0; k < N; k++) begin
            len = (d[k] == 0) ? 1 : ((d[k] < T) ? d[k] : T);
            repeat (len) sched.push_back(mk(0, 0, 0, 0, N'(1) << k, 0, 0, 1, '0));
            sched.push_back(mk(0, 1, 0, 0, '0, 0, 0, 1, (d[k] > T) ? (N'(1) << k) : '0));
        end
        sched.push_back(mk(0, 0, 0, 0, '0, 0, 1, 1, '0));
    endtask

    task automatic compare();
        if (reset) begin
            chk("rst_outputs", {init, idle, gen_move, apply_move, draw, hit, busy,
                                frame_done, draw_err, overrun}, 0);
        end else begin
            chk("init", init, cur.init);
            chk("idle", idle, cur.idle);
            chk("gen_move", gen_move, cur.gen);
            chk("apply_move", apply_move, cur.apply);
            chk("draw", draw, cur.draw);
            chk("hit", hit, cur.hitcyc ? pend : '0);
            chk("busy", busy, cur.busy);
            chk("frame_done", frame_done, cur.done);
            chk("draw_err", draw_err, eerr);
            chk("overrun", overrun, eov);
        end
    endtask

    task automatic enemies_and_observe();
        for (int k = 0; k < N; k++) begin
            if (idle) begin
                cnt[k] = 0;
                draw_done[k] = (d[k] == 0);
            end else if (draw[k]) begin
                cnt[k]++;
                if (cnt[k] >= d[k]) draw_done[k] = 1'b1;
            end
            if (draw[k]) run[k]++;
            else if (run[k] > 0) begin
                last_run[k] = run[k];
                run[k] = 0;
            end
        end
        if (frame_done) fd_count++;
    endtask

    task automatic model_step(input bit fs, input logic [N-1:0] ah, input bit rst);
        if (rst) begin
            sched.delete();
            pend = '0;
            eerr = '0;
            eov  = 1'b0;
            cur  = mk(1, 0, 0, 0, '0, 0, 0, 1, '0);
        end else begin
            if (fs) begin
                if (cur.busy) eov = 1'b1;
                else accept(ah);
            end
            pend = cur.hitcyc ? ah : (pend | ah);
            cur = (sched.size() > 0) ? sched.pop_front() : mk(0, 1, 0, 0, '0, 0, 0, 0, '0);
            eerr |= cur.errset;
        end
    endtask

    task automatic cycle(input bit fs, input logic [N-1:0] ah, input bit rst);
        @(posedge clock);
        #1;
        frame_start = fs;
        attack_hit  = ah;
        reset       = rst;
        #1;
        compare();
        enemies_and_observe();
        model_step(fs, ah, rst);
    endtask

    task automatic wait_frame(input string name);
        int start;
        int budget;
        start  = fd_count;
        budget = 0;
        while (fd_count == start && budget < 3000) begin
            cycle(0, '0, 0);
            budget++;
        end
        chk({name, "_frame_done_seen"}, fd_count - start, 1);
        repeat (3) cycle(0, '0, 0);
    endtask

    initial begin
        int budget;
        bit rst_r;
        cur = mk(0, 1, 0, 0, '0, 0, 0, 0, '0);

        // Scenario 1: reset release, init pulse, first-frame latency
        repeat (3) cycle(0, '0, 1);
        cycle(0, '0, 0);
        chk("lit_init_after_reset", init, 1);
        cycle(0, '0, 0);
        chk("lit_init_once", init, 0);
        chk("lit_idle_after_init", {idle, busy}, 2'b10);
        dir_d = '{258, 258, 258, 258};
        cycle(1, '0, 0);
        cycle(0, '0, 0);
        chk("lit_gen_t1", gen_move, 1);
        cycle(0, '0, 0);
        chk("lit_apply_t2", apply_move, 1);
        cycle(0, '0, 0);
        chk("lit_draw_t3", draw, 4'b0001);

        // Scenario 2: each enemy finishes 258 cycles into its window
        wait_frame("s2");
        for (int k = 0; k < N; k++) chk("lit_run_258", last_run[k], 258);
        chk("lit_s2_idle", {idle, busy, draw_err}, 6'b10_0000);

        // Scenario 3: hit arrives during enemy 1 drawing, delivered next frame only
        dir_d = '{5, 5, 5, 5};
        cycle(1, '0, 0);
        budget = 0;
        while (draw != 4'b0010 && budget < 100) begin
            cycle(0, '0, 0);
            budget++;
        end
        chk("s3_reach_draw1", draw, 4'b0010);
        cycle(0, 4'b0100, 0);
        chk("lit_no_hit_while_draw", hit, 0);
        wait_frame("s3a");
        cycle(1, '0, 0);
        cycle(0, '0, 0);
        chk("lit_hit_delivered", hit, 4'b0100);
        cycle(0, '0, 0);
        chk("lit_gen_after_hit", {gen_move, hit}, 5'b1_0000);
        wait_frame("s3b");
        cycle(1, '0, 0);
        cycle(0, '0, 0);
        chk("lit_no_repeat_hit", {gen_move, hit}, 5'b1_0000);
        wait_frame("s3c");

        // Scenario 4: enemy 2 never finishes
        dir_d = '{5, 5, 1000, 5};
        cycle(1, '0, 0);
        wait_frame("s4");
        chk("lit_timeout_len", last_run[2], 300);
        chk("lit_draw_err", draw_err, 4'b0100);
        chk("lit_enemy3_drawn", last_run[3], 5);

        // Scenario 5: overrun while busy, then reset in the middle of DRAW
        dir_d = '{40, 40, 40, 40};
        cycle(1, '0, 0);
        repeat (10) cycle(0, '0, 0);
        cycle(1, '0, 0);
        cycle(0, '0, 0);
        chk("lit_overrun", overrun, 1);
        chk("lit_no_restart", draw, 4'b0001);
        repeat (5) cycle(0, '0, 0);
        cycle(0, '0, 1);
        chk("lit_reset_zero", {draw, draw_err, overrun, busy}, 0);
        cycle(0, '0, 1);
        cycle(0, '0, 0);
        chk("lit_init_after_midreset", {init, draw, draw_err, overrun}, 10'b1_0000_0000_0);
        repeat (3) cycle(0, '0, 0);

        // Random traffic against the schedule model
        use_dir = 1'b0;
        rst_r = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (rst_r) rst_r = ($urandom_range(0, 1) == 0);
            else       rst_r = ($urandom_range(0, 999) == 0);
            cycle($urandom_range(0, 24) == 0,
                  ($urandom_range(0, 7) == 0) ? N'($urandom) : '0, rst_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
